zstd_header_parser: RTL and testbench
=====================================

Name: zstd_header_parser

Overview:
- Parses a Zstandard frame header (magic number, Frame_Header_Descriptor, optional Window_Descriptor, Dictionary_ID and Frame_Content_Size) from a 16-bit little-endian word stream.
- Sits at the front of the decompressor and hands decoded header fields to the block decoder.
- When the header length is odd, it also returns the first byte that follows the header.

Parameters:
- MAGIC, 32'hFD2FB528: expected frame magic number (little-endian on the wire).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle pulse; the data_in sampled in this cycle is header word 0.
- data_in  input  16  header word; [7:0] is the earlier byte, [15:8] the later byte.
- finished  output  1  registered; high once all header bytes are consumed.
- sizes  output  8  [7] = Window_Descriptor present, [6:4] = DID byte count (0/1/2/4), [3:0] = FCS byte count (0/1/2/4/8).
- Frame_Header_Descriptor  output  8  FHD byte.
- Window_Descriptor  output  8  WD byte; 0 when absent.
- Dictionary_ID  output  32  little-endian DID, zero-extended; 0 when absent.
- Frame_Content_Size  output  64  little-endian FCS, zero-extended; +256 applied for the 2-byte form; 0 when absent.
- extra_byte  output  8  high byte of the last word when total header-body length is odd; else 0.

Behaviour:
- Reset (async, reset=0): every output = 0; FSM = IDLE.
- FSM states: IDLE, MAGIC_HI, BODY, DONE.
- IDLE: if start=1, capture data_in as magic[15:0] and go to MAGIC_HI. All field registers and finished are cleared in the same edge.
- MAGIC_HI: capture magic[31:16] and go to BODY. In the base build the magic value is not checked.
- Body byte stream starts at word 2: byte b0 is the FHD, followed in order by WD, then DID, then FCS.
- Field sizes are decoded from the FHD:
  - WD present iff FHD[5]=0.
  - DID size from FHD[1:0]: 0→0, 1→1, 2→2, 3→4 bytes.
  - FCS size from FHD[7:6]: 0→(FHD[5] ? 1 : 0), 1→2, 2→4, 3→8 bytes.
- Total body length T = 1 + WD + DID + FCS, with T ≤ 14. The body occupies ceil(T/2) words.
- BODY: consume two bytes per cycle and route each byte by its body index to the correct field and byte lane. The FHD-derived sizes must be applied to the high byte of word 2 in the same cycle.
- On the edge that samples the final body word:
  - finished goes to 1 and the FSM goes to DONE.
  - If T is odd, extra_byte = data_in[15:8].
  - A 2-byte FCS gets +256 applied at this point.
- Latency: finished rises on the edge that samples word 1 + ceil(T/2), i.e. 2 + ceil(T/2) sampled words including word 0.
- DONE: all outputs hold and finished stays 1 until reset or a new start.
- A start in any state, including mid-parse, aborts the current parse and restarts at IDLE semantics: magic low is captured and outputs are cleared.
- FHD bits 4, 3 and 2 (unused, reserved, checksum) are ignored.
- data_in is don't-care in IDLE without start, and in DONE.

Optional Feature:
- HEADER_MAGIC_CHECK_EN:
  - When defined, add output bad_magic (1 bit, reset 0).
  - In MAGIC_HI, if the captured magic ≠ MAGIC: set bad_magic=1, leave finished=0, and return to IDLE.
  - bad_magic clears on the next start.
- When undefined: no bad_magic port and no magic comparison.

Decomposition:
- Package zstd_pkg holds:
  - MAGIC default constant;
  - FSM state enum;
  - functions did_bytes(fhd), fcs_bytes(fhd) and wd_present(fhd).
- One sub-module is natural: zstd_fhd_decode, a combinational block mapping FHD to sizes, total length T and field byte offsets.

Test Plan:
- Words B528, FD2F, 0520 → finished=1 after the 3rd word. FHD=0x20, sizes=0x01, FCS=0x05, WD=0, DID=0, extra_byte=0x00.
- Words B528, FD2F, 1163, 3322, 3444, AB12 → FHD=0x63, sizes=0x42, DID=0x44332211, FCS=0x1334 (0x1234+256), extra_byte=0xAB.
- Words B528, FD2F, 5800 → FHD=0x00, WD=0x58, sizes=0x80, FCS=0, DID=0, extra_byte=0.
- FHD=0xE0 (single segment, 8-byte FCS): words B528, FD2F, 01E0, 0302, 0504, 0706, CC08 → FCS=0x0807060504030201, extra_byte=0xCC, finished after the 7th word.
- Assert reset low mid-body → all outputs 0 immediately. Pulse start mid-parse → parse restarts from the new word 0.
- With HEADER_MAGIC_CHECK_EN: words 1234, FD2F → bad_magic=1, finished stays 0, FSM returns to IDLE.

Source files
------------

// File: rtl/zstd_pkg.sv
// Shared constants, FSM state encoding and FHD field-size helpers for the Zstandard frame header parser.
package zstd_pkg;

  localparam logic [31:0] MAGIC_DEFAULT = 32'hFD2FB528;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MAGIC_HI = 2'd1,
    ST_BODY     = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  function automatic logic wd_present(input logic [7:0] fhd);
    return ~fhd[5];
  endfunction

  function automatic logic [2:0] did_bytes(input logic [7:0] fhd);
    case (fhd[1:0])
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Single-segment frames without an explicit FCS flag still carry a 1-byte FCS.
  function automatic logic [3:0] fcs_bytes(input logic [7:0] fhd);
    case (fhd[7:6])
      2'd0:    return fhd[5] ? 4'd1 : 4'd0;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/zstd_fhd_decode.sv
// Combinational decode of a Frame_Header_Descriptor into field sizes, body length and byte offsets.
module zstd_fhd_decode
  import zstd_pkg::*;
(
  input  logic [7:0] fhd,
  output logic       wd_c,
  output logic [7:0] sizes_c,
  output logic [3:0] did_off_c,
  output logic [3:0] fcs_off_c,
  output logic [3:0] total_c
);

  logic [2:0] did_n;
  logic [3:0] fcs_n;

  always_comb begin
    wd_c      = wd_present(fhd);
    did_n     = did_bytes(fhd);
    fcs_n     = fcs_bytes(fhd);
    did_off_c = 4'd1 + 4'(wd_c);
    fcs_off_c = did_off_c + 4'(did_n);
    total_c   = fcs_off_c + fcs_n;
    sizes_c   = {wd_c, did_n, fcs_n};
  end

endmodule

// File: rtl/zstd_header_parser.sv
// Zstandard frame header parser over a 16-bit little-endian word stream.
// Define HEADER_MAGIC_CHECK_EN to add magic-number validation and the bad_magic output.
module zstd_header_parser
`ifdef HEADER_MAGIC_CHECK_EN
  #(parameter logic [31:0] MAGIC = zstd_pkg::MAGIC_DEFAULT)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic        finished,
  output logic [7:0]  sizes,
  output logic [7:0]  Frame_Header_Descriptor,
  output logic [7:0]  Window_Descriptor,
  output logic [31:0] Dictionary_ID,
  output logic [63:0] Frame_Content_Size,
  output logic [7:0]  extra_byte
`ifdef HEADER_MAGIC_CHECK_EN
  ,
  output logic        bad_magic
`endif
);

  import zstd_pkg::*;

  state_e      state_q, state_d;
  logic [2:0]  bidx_q, bidx_d;
  logic        finished_q, finished_d;
  logic [7:0]  sizes_q, sizes_d;
  logic [7:0]  fhd_q, fhd_d;
  logic [7:0]  wd_q, wd_d;
  logic [31:0] did_q, did_d;
  logic [63:0] fcs_q, fcs_d;
  logic [7:0]  extra_q, extra_d;

  logic [7:0]  fhd_cur_c;
  logic        wd_c;
  logic [7:0]  sizes_c;
  logic [3:0]  did_off_c;
  logic [3:0]  fcs_off_c;
  logic [3:0]  total_c;
  logic        last_c;
  logic [3:0]  bi_c;

`ifdef HEADER_MAGIC_CHECK_EN
  logic [15:0] magic_lo_q, magic_lo_d;
  logic        bad_magic_q, bad_magic_d;
  logic        magic_bad_c;

  assign magic_bad_c = ({data_in, magic_lo_q} != MAGIC);
  assign bad_magic   = bad_magic_q;
`endif

  // The FHD arrives in the low byte of the first body word; its sizes steer the high byte in the same cycle.
  assign fhd_cur_c = (bidx_q == 3'd0) ? data_in[7:0] : fhd_q;
  assign last_c    = ({1'b0, bidx_q, 1'b0} + 5'd2) >= {1'b0, total_c};

  zstd_fhd_decode u_fhd_decode (
    .fhd       (fhd_cur_c),
    .wd_c      (wd_c),
    .sizes_c   (sizes_c),
    .did_off_c (did_off_c),
    .fcs_off_c (fcs_off_c),
    .total_c   (total_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_MAGIC_HI;
    end else begin
      case (state_q)
`ifdef HEADER_MAGIC_CHECK_EN
        ST_MAGIC_HI: state_d = magic_bad_c ? ST_IDLE : ST_BODY;
`else
        ST_MAGIC_HI: state_d = ST_BODY;
`endif
        ST_BODY:     if (last_c) state_d = ST_DONE;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bidx_d     = bidx_q;
    finished_d = finished_q;
    sizes_d    = sizes_q;
    fhd_d      = fhd_q;
    wd_d       = wd_q;
    did_d      = did_q;
    fcs_d      = fcs_q;
    extra_d    = extra_q;
    bi_c       = 4'd0;
`ifdef HEADER_MAGIC_CHECK_EN
    magic_lo_d  = magic_lo_q;
    bad_magic_d = bad_magic_q;
`endif
    if (start) begin
      bidx_d     = 3'd0;
      finished_d = 1'b0;
      sizes_d    = 8'd0;
      fhd_d      = 8'd0;
      wd_d       = 8'd0;
      did_d      = 32'd0;
      fcs_d      = 64'd0;
      extra_d    = 8'd0;
`ifdef HEADER_MAGIC_CHECK_EN
      magic_lo_d  = data_in;
      bad_magic_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_MAGIC_HI: begin
          bidx_d = 3'd0;
`ifdef HEADER_MAGIC_CHECK_EN
          bad_magic_d = magic_bad_c;
`endif
        end
        ST_BODY: begin
          bidx_d = bidx_q + 3'd1;
          // Route each byte lane by its body index into the owning field.
          for (int j = 0; j < 2; j++) begin
            bi_c = {bidx_q, 1'b0} + 4'(j);
            if (bi_c == 4'd0) begin
              fhd_d   = data_in[8*j +: 8];
              sizes_d = sizes_c;
            end else if (wd_c && bi_c == 4'd1) begin
              wd_d = data_in[8*j +: 8];
            end else if (bi_c >= did_off_c && bi_c < fcs_off_c) begin
              did_d[{2'(bi_c - did_off_c), 3'b000} +: 8] = data_in[8*j +: 8];
            end else if (bi_c >= fcs_off_c && bi_c < total_c) begin
              fcs_d[{3'(bi_c - fcs_off_c), 3'b000} +: 8] = data_in[8*j +: 8];
            end
          end
          if (last_c) begin
            finished_d = 1'b1;
            if (total_c[0]) extra_d = data_in[15:8];
            if (sizes_c[3:0] == 4'd2) fcs_d = fcs_d + 64'd256;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bidx_q     <= 3'd0;
      finished_q <= 1'b0;
      sizes_q    <= 8'd0;
      fhd_q      <= 8'd0;
      wd_q       <= 8'd0;
      did_q      <= 32'd0;
      fcs_q      <= 64'd0;
      extra_q    <= 8'd0;
    end else begin
      bidx_q     <= bidx_d;
      finished_q <= finished_d;
      sizes_q    <= sizes_d;
      fhd_q      <= fhd_d;
      wd_q       <= wd_d;
      did_q      <= did_d;
      fcs_q      <= fcs_d;
      extra_q    <= extra_d;
    end
  end

`ifdef HEADER_MAGIC_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      magic_lo_q  <= 16'd0;
      bad_magic_q <= 1'b0;
    end else begin
      magic_lo_q  <= magic_lo_d;
      bad_magic_q <= bad_magic_d;
    end
  end
`endif

  assign finished                = finished_q;
  assign sizes                   = sizes_q;
  assign Frame_Header_Descriptor = fhd_q;
  assign Window_Descriptor       = wd_q;
  assign Dictionary_ID           = did_q;
  assign Frame_Content_Size      = fcs_q;
  assign extra_byte              = extra_q;

endmodule

// File: tb/tb_zstd_header_parser.sv
// Self-checking bench for zstd_header_parser: directed frames against a byte-level header model.
module tb_zstd_header_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] data_in;
  logic        finished;
  logic [7:0]  sizes;
  logic [7:0]  fhd;
  logic [7:0]  wd;
  logic [31:0] did;
  logic [63:0] fcs;
  logic [7:0]  extra_byte;
`ifdef HEADER_MAGIC_CHECK_EN
  logic        bad_magic;
`endif

  zstd_header_parser dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .data_in                 (data_in),
    .finished                (finished),
    .sizes                   (sizes),
    .Frame_Header_Descriptor (fhd),
    .Window_Descriptor       (wd),
    .Dictionary_ID           (did),
    .Frame_Content_Size      (fcs),
    .extra_byte              (extra_byte)
`ifdef HEADER_MAGIC_CHECK_EN
    ,
    .bad_magic               (bad_magic)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] frame_q[$];
  logic [7:0]  e_fhd, e_sizes, e_wd, e_extra;
  logic [31:0] e_did;
  logic [63:0] e_fcs;
  int          e_nwords;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Walk the body bytes in wire order, peeling off each field per the FHD flags.
  task automatic model();
    logic [7:0] b[$];
    int did_n, fcs_n, wdp, t, pos;
    b = {};
    for (int i = 2; i < frame_q.size(); i++) begin
      b.push_back(frame_q[i][7:0]);
      b.push_back(frame_q[i][15:8]);
    end
    e_fhd = b[0];
    wdp = e_fhd[5] ? 0 : 1;
    case (e_fhd[1:0])
      2'd0: did_n = 0;
      2'd1: did_n = 1;
      2'd2: did_n = 2;
      default: did_n = 4;
    endcase
    case (e_fhd[7:6])
      2'd0: fcs_n = e_fhd[5] ? 1 : 0;
      2'd1: fcs_n = 2;
      2'd2: fcs_n = 4;
      default: fcs_n = 8;
    endcase
    t = 1 + wdp + did_n + fcs_n;
    pos = 1;
    e_wd = (wdp == 1) ? b[pos] : 8'h00;
    pos += wdp;
    e_did = 32'd0;
    for (int k = 0; k < did_n; k++) e_did |= 32'(b[pos + k]) << (8 * k);
    pos += did_n;
    e_fcs = 64'd0;
    for (int k = 0; k < fcs_n; k++) e_fcs |= 64'(b[pos + k]) << (8 * k);
    if (fcs_n == 2) e_fcs += 64'd256;
    e_extra = (t % 2 == 1) ? b[t] : 8'h00;
    e_sizes = {1'(wdp), 3'(did_n), 4'(fcs_n)};
    e_nwords = (t + 1) / 2;
  endtask

  task automatic check_fields(input string tag);
    check({tag, "/sizes"}, 64'(sizes), 64'(e_sizes));
    check({tag, "/fhd"}, 64'(fhd), 64'(e_fhd));
    check({tag, "/wd"}, 64'(wd), 64'(e_wd));
    check({tag, "/did"}, 64'(did), 64'(e_did));
    check({tag, "/fcs"}, fcs, e_fcs);
    check({tag, "/extra"}, 64'(extra_byte), 64'(e_extra));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "/finished"}, 64'(finished), 64'd0);
    check({tag, "/sizes"}, 64'(sizes), 64'd0);
    check({tag, "/fhd"}, 64'(fhd), 64'd0);
    check({tag, "/wd"}, 64'(wd), 64'd0);
    check({tag, "/did"}, 64'(did), 64'd0);
    check({tag, "/fcs"}, fcs, 64'd0);
    check({tag, "/extra"}, 64'(extra_byte), 64'd0);
  endtask

  // Drive the queued frame, checking finished every cycle and the fields once DONE holds.
  task automatic run_frame(input string tag);
    model();
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      start   = (i == 0);
      data_in = frame_q[i];
      @(posedge clk);
      #1;
      check({tag, "/finished"}, 64'(finished), 64'(i >= 1 + e_nwords));
    end
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'($urandom);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold"}, 64'(finished), 64'd1);
      @(negedge clk);
      data_in = 16'($urandom);
    end
    check_fields(tag);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    data_in = 16'h0000;
    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    frame_q = {16'hB528, 16'hFD2F, 16'h0520};
    run_frame("t1");
    check("t1/lit_fcs", fcs, 64'h5);
    check("t1/lit_sizes", 64'(sizes), 64'h01);

    frame_q = {16'hB528, 16'hFD2F, 16'h1163, 16'h3322, 16'h3444, 16'hAB12};
    run_frame("t2");
    check("t2/lit_did", 64'(did), 64'h44332211);
    check("t2/lit_fcs", fcs, 64'h1334);
    check("t2/lit_extra", 64'(extra_byte), 64'hAB);
    check("t2/lit_sizes", 64'(sizes), 64'h42);

    frame_q = {16'hB528, 16'hFD2F, 16'h5800};
    run_frame("t3");
    check("t3/lit_wd", 64'(wd), 64'h58);
    check("t3/lit_sizes", 64'(sizes), 64'h80);

    frame_q = {16'hB528, 16'hFD2F, 16'h01E0, 16'h0302, 16'h0504, 16'h0706, 16'hCC08};
    run_frame("t4");
    check("t4/lit_fcs", fcs, 64'h0807060504030201);
    check("t4/lit_extra", 64'(extra_byte), 64'hCC);

    frame_q = {16'hB528, 16'hFD2F, 16'h4A81, 16'h1177, 16'h3322, 16'h9944};
    run_frame("t5");
    check("t5/lit_wd", 64'(wd), 64'h4A);
    check("t5/lit_did", 64'(did), 64'h77);
    check("t5/lit_fcs", fcs, 64'h44332211);
    check("t5/lit_sizes", 64'(sizes), 64'h94);
    check("t5/lit_extra", 64'(extra_byte), 64'h99);

    frame_q = {16'hB528, 16'hFD2F, 16'h5AC3, 16'h2211, 16'h4433,
               16'hA1A0, 16'hA3A2, 16'hA5A4, 16'hA7A6};
    run_frame("t6");
    check("t6/lit_fcs", fcs, 64'hA7A6A5A4A3A2A1A0);

    // Async reset in the middle of a body.
    frame_q = {16'hB528, 16'hFD2F, 16'h1163, 16'h3322};
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      start   = (i == 0);
      data_in = frame_q[i];
      @(posedge clk);
      #1;
      check("rst_mid/finished", 64'(finished), 64'd0);
    end
    @(negedge clk);
    start = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_rel");

    // Start pulse mid-parse restarts from the new word 0.
    frame_q = {16'hB528, 16'hFD2F, 16'h1163};
    for (int i = 0; i < frame_q.size(); i++) begin
      @(negedge clk);
      start   = (i == 0);
      data_in = frame_q[i];
    end
    frame_q = {16'hB528, 16'hFD2F, 16'h0520};
    run_frame("restart");
    check("restart/lit_did", 64'(did), 64'h0);
    check("restart/lit_fcs", fcs, 64'h5);

`ifdef HEADER_MAGIC_CHECK_EN
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'h1234;
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'hFD2F;
    @(posedge clk);
    #1;
    check("magic/bad", 64'(bad_magic), 64'd1);
    check("magic/finished", 64'(finished), 64'd0);
    @(negedge clk);
    data_in = 16'h0520;
    @(posedge clk);
    #1;
    check("magic/idle", 64'(finished), 64'd0);
    frame_q = {16'hB528, 16'hFD2F, 16'h0520};
    run_frame("magic_ok");
    check("magic_ok/bad", 64'(bad_magic), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
